// File: rtl/add8u_mon_pkg.sv
// Shared types and widths for the approximate-adder error monitor.
// Holds the monitor state enum and the operand/sum/error/square widths.
package add8u_mon_pkg;

    localparam int ADD_W = 8;
    localparam int SUM_W = 9;
    localparam int ERR_W = 9;
    localparam int SQ_W  = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/add8u_err_stage.sv
// Combinational error evaluation for one adder sample.
// Ports: a, b operands; o approximate sum; abs_err |o-(a+b)|; err_flag
// abs_err!=0; sq_err abs_err^2 (only with ADD8U_MON_SQERR_EN).
module add8u_err_stage
    import add8u_mon_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic [SUM_W-1:0] o,
    output logic [ERR_W-1:0] abs_err,
    output logic             err_flag
`ifdef ADD8U_MON_SQERR_EN
    ,
    output logic [SQ_W-1:0]  sq_err
`endif
);

    logic [SUM_W-1:0]        exact;
    logic signed [SUM_W:0]   diff;
    logic [SUM_W:0]          mag;

    always_comb begin
        exact = SUM_W'(a) + SUM_W'(b);
        // one extra bit so 0..511 minus 0..510 never wraps
        diff  = $signed({1'b0, o}) - $signed({1'b0, exact});
        mag   = diff[SUM_W] ? -diff : diff;
        abs_err  = mag[ERR_W-1:0];
        err_flag = (abs_err != '0);
    end

`ifdef ADD8U_MON_SQERR_EN
    logic [SQ_W-1:0] ext;

    always_comb begin
        ext    = SQ_W'(abs_err);
        sq_err = ext * ext;
    end
`endif

endmodule

// File: rtl/add8u_err_monitor.sv
// Windowed error statistics for an 8-bit approximate unsigned adder.
// Ports: clk, rst (async high), start, in_valid/in_ready, in_a, in_b, in_o;
// busy, done, err_count, sum_abs_err, max_abs_err, and sum_sq_err when
// ADD8U_MON_SQERR_EN is defined. Two-stage pipe: stage 1 registers the
// per-sample error, stage 2 accumulates it.
module add8u_err_monitor
    import add8u_mon_pkg::*;
#(
    parameter int WINDOW_LOG2 = 4
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADD_W-1:0]            in_a,
    input  logic [ADD_W-1:0]            in_b,
    input  logic [SUM_W-1:0]            in_o,
    output logic                        busy,
    output logic                        done,
    output logic [WINDOW_LOG2:0]        err_count,
    output logic [ERR_W+WINDOW_LOG2-1:0] sum_abs_err,
    output logic [ERR_W-1:0]            max_abs_err
`ifdef ADD8U_MON_SQERR_EN
    ,
    output logic [SQ_W+WINDOW_LOG2-1:0] sum_sq_err
`endif
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam int AW = ERR_W + WINDOW_LOG2;
    localparam logic [CW-1:0] LAST = CW'((1 << WINDOW_LOG2) - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             s1_valid;
    logic             s1_flag;
    logic [ERR_W-1:0] s1_abs;
    logic [ERR_W-1:0] abs_err;
    logic             err_flag;
    logic             accept;
    logic             arm;

`ifdef ADD8U_MON_SQERR_EN
    localparam int QW = SQ_W + WINDOW_LOG2;
    logic [SQ_W-1:0] sq_err;
    logic [SQ_W-1:0] s1_sq;
`endif

    add8u_err_stage u_err (
        .a        (in_a),
        .b        (in_b),
        .o        (in_o),
        .abs_err  (abs_err),
        .err_flag (err_flag)
`ifdef ADD8U_MON_SQERR_EN
        ,
        .sq_err   (sq_err)
`endif
    );

    // in_ready is a registered copy of (state == RUN)
    assign accept = in_valid && in_ready;
    assign arm    = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            s1_valid    <= 1'b0;
            s1_flag     <= 1'b0;
            s1_abs      <= '0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
`ifdef ADD8U_MON_SQERR_EN
            s1_sq       <= '0;
            sum_sq_err  <= '0;
`endif
        end else begin
            // stage 1
            s1_valid <= accept;
            if (accept) begin
                s1_abs  <= abs_err;
                s1_flag <= err_flag;
`ifdef ADD8U_MON_SQERR_EN
                s1_sq   <= sq_err;
`endif
            end

            // stage 2; arm only fires with an empty pipe
            if (arm) begin
                err_count   <= '0;
                sum_abs_err <= '0;
                max_abs_err <= '0;
`ifdef ADD8U_MON_SQERR_EN
                sum_sq_err  <= '0;
`endif
            end else if (s1_valid) begin
                err_count   <= err_count + CW'(s1_flag);
                sum_abs_err <= sum_abs_err + AW'(s1_abs);
                if (s1_abs > max_abs_err)
                    max_abs_err <= s1_abs;
`ifdef ADD8U_MON_SQERR_EN
                sum_sq_err  <= sum_sq_err + QW'(s1_sq);
`endif
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
